// File: rtl/pwm_tx.sv
// pwm_tx: PWM transmitter with a double-buffered duty word.
// A new duty word is held in a shadow register and applied only at a period
// boundary, or right away while disabled.
// Optional feature macro: PWM_TX_PERIOD_STROBE_EN adds a one-cycle
// period_strobe output that pulses at the start of every new period.
module pwm_tx #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic [WIDTH-1:0] active_duty,
   output logic             pwm_out
`ifdef PWM_TX_PERIOD_STROBE_EN
   ,
   output logic             period_strobe
`endif
);

   // The prescaler needs at least one bit, even when PRESCALE is 1.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0]    pre;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] shadow;
   logic             shadow_full;
   logic             accept;
   logic             tick;
   logic             boundary;

   assign duty_ready = !shadow_full && !rst;
   assign accept     = duty_valid && duty_ready;
   assign tick       = enable && (pre == PRE_MAX);
   assign boundary   = tick && (cnt == '1);

   // Counters, shadow/active duty handoff and the registered compare output.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre         <= '0;
         cnt         <= '0;
         shadow_full <= 1'b0;
         active_duty <= '0;
         pwm_out     <= 1'b0;
      end else begin
         if (!enable) begin
            pre     <= '0;
            cnt     <= '0;
            pwm_out <= 1'b0;
            // Nothing is being transmitted, so a pending word applies at once.
            if (shadow_full) begin
               active_duty <= shadow;
               shadow_full <= 1'b0;
            end
         end else begin
            pre     <= tick ? '0 : pre + PW'(1);
            if (tick) cnt <= cnt + WIDTH'(1);
            pwm_out <= (cnt < active_duty);
            // Only swap duty at the end of a full period so no period is glitched.
            if (boundary && shadow_full) begin
               active_duty <= shadow;
               shadow_full <= 1'b0;
            end
         end
         // Acceptance requires an empty shadow, so it never collides with a load.
         if (accept) begin
            shadow      <= duty_in;
            shadow_full <= 1'b1;
         end
      end
   end

`ifdef PWM_TX_PERIOD_STROBE_EN
   // One-cycle pulse coincident with cnt==0 of each new period.
   always_ff @(posedge clk) begin
      if (rst) period_strobe <= 1'b0;
      else     period_strobe <= boundary;
   end
`endif

endmodule

// File: tb/tb_pwm_tx.sv
// tb_pwm_tx: directed bench for pwm_tx.
// u0 runs PRESCALE=1 (256-cycle period), u1 runs PRESCALE=4 (1024-cycle period).
module tb_pwm_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, enable, duty_valid, duty_ready, pwm_out;
   logic [7:0] duty_in, active_duty;
   logic       rst4, en4, dv4, dr4, pwm4;
   logic [7:0] di4, ad4;
`ifdef PWM_TX_PERIOD_STROBE_EN
   logic       period_strobe, strobe4;
`endif

   pwm_tx #(.WIDTH(8), .PRESCALE(1)) u0 (
      .clk(clk), .rst(rst), .enable(enable), .duty_in(duty_in),
      .duty_valid(duty_valid), .duty_ready(duty_ready),
      .active_duty(active_duty), .pwm_out(pwm_out)
`ifdef PWM_TX_PERIOD_STROBE_EN
      , .period_strobe(period_strobe)
`endif
   );

   pwm_tx #(.WIDTH(8), .PRESCALE(4)) u1 (
      .clk(clk), .rst(rst4), .enable(en4), .duty_in(di4),
      .duty_valid(dv4), .duty_ready(dr4),
      .active_duty(ad4), .pwm_out(pwm4)
`ifdef PWM_TX_PERIOD_STROBE_EN
      , .period_strobe(strobe4)
`endif
   );

   int vectors = 0;
   int errors  = 0;
   int cyc, arm, last_acc;
   logic [7:0] pend[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One u0 clock: offer the next pending word once the slot reaches arm,
   // then drop valid after it has been taken.
   task automatic step();
      logic acc;
      if (!duty_valid && pend.size() > 0 && (cyc % 256) >= arm) begin
         duty_valid = 1'b1;
         duty_in    = pend.pop_front();
      end
      acc = duty_valid && duty_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
         last_acc   = cyc;
         duty_valid = 1'b0;
      end
   endtask

   task automatic run_period(input string tag, input int exp_hi);
      int hi = 0;
      for (int i = 0; i < 256; i++) begin
         if (pwm_out) hi++;
         step();
      end
      chk(tag, hi, exp_hi);
   endtask

   initial begin
      int hi0, hi1, ns, s0, s1;
      rst = 1'b1; enable = 1'b0; duty_valid = 1'b0; duty_in = '0;
      rst4 = 1'b1; en4 = 1'b0; dv4 = 1'b0; di4 = '0;
      arm = 0; cyc = 0; last_acc = -1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_active", active_duty, 0);
      chk("rst_ready", duty_ready, 0);
`ifdef PWM_TX_PERIOD_STROBE_EN
      chk("rst_strobe", period_strobe, 0);
`endif
      rst = 1'b0; #1;
      chk("ready_after_rst", duty_ready, 1);

      // Disabled: the word applies one cycle after acceptance.
      duty_in = 8'd64; duty_valid = 1'b1;
      @(posedge clk); #1;
      duty_valid = 1'b0;
      chk("dis_ready_low", duty_ready, 0);
      chk("dis_active_old", active_duty, 0);
      @(posedge clk); #1;
      chk("dis_active_new", active_duty, 64);
      chk("dis_ready_back", duty_ready, 1);

      // Enable: pwm rises one cycle later; slot 0 of period 0 starts here.
      enable = 1'b1;
      @(posedge clk); #1;
      cyc = 0;
      chk("pwm_rise", pwm_out, 1);
      run_period("p0_hi64", 64);
      run_period("p1_hi64", 64);
      chk("active_64", active_duty, 64);

      // Duty 0 then 255, each taken mid-period and applied at the boundary.
      arm = 10; pend.push_back(8'd0);
      run_period("p2_old64", 64);
      pend.push_back(8'd255);
      run_period("p3_duty0", 0);
      pend.push_back(8'd64);
      run_period("p4_duty255", 255);
      chk("active_back64", active_duty, 64);

      // 200 mid-period, then 100 held until the shadow drains at the boundary.
      arm = 100; pend.push_back(8'd200); pend.push_back(8'd100);
      run_period("p5_hi64", 64);
      chk("acc100_after_bnd", last_acc, 256 * 6);
      chk("ready_low_100", duty_ready, 0);
      run_period("p6_hi200", 200);

      // Word offered in the boundary cycle itself.
      arm = 254; pend.push_back(8'd30);
      run_period("p7_hi100", 100);
      chk("acc_in_bnd", last_acc, 256 * 7 + 255);
      run_period("p8_old_repeat", 100);
      run_period("p9_hi30", 30);

      // Reset mid-high-phase with a full shadow.
      arm = 5; pend.push_back(8'd77);
      repeat (10) step();
      chk("pre_rst_pwm", pwm_out, 1);
      chk("pre_rst_full", duty_ready, 0);
      rst = 1'b1; #1;
      chk("rst_ready_mid", duty_ready, 0);
      step();
      chk("rst_mid_pwm", pwm_out, 0);
      chk("rst_mid_active", active_duty, 0);
      rst = 1'b0; #1;
      chk("rst_mid_ready", duty_ready, 1);
      run_period("post_rst_lost", 0);
      chk("post_rst_active", active_duty, 0);

      // PRESCALE=4, duty 128.
      rst4 = 1'b0;
      @(posedge clk); #1;
      di4 = 8'd128; dv4 = 1'b1;
      @(posedge clk); #1;
      dv4 = 1'b0;
      @(posedge clk); #1;
      chk("p4_active", ad4, 128);
`ifdef PWM_TX_PERIOD_STROBE_EN
      chk("p4_strobe_dis", strobe4, 0);
`endif
      en4 = 1'b1;
      @(posedge clk); #1;
      hi0 = 0; hi1 = 0; ns = 0; s0 = -1; s1 = -1;
      for (int k = 0; k < 2048; k++) begin
         if (pwm4) begin
            if (k < 1024) hi0++;
            else          hi1++;
         end
`ifdef PWM_TX_PERIOD_STROBE_EN
         if (strobe4) begin
            if (ns == 0) s0 = k;
            else if (ns == 1) s1 = k;
            ns++;
         end
`endif
         @(posedge clk); #1;
      end
      chk("ps4_hi_p0", hi0, 512);
      chk("ps4_hi_p1", hi1, 512);
`ifdef PWM_TX_PERIOD_STROBE_EN
      chk("strobe_count", ns, 2);
      chk("strobe_first", s0, 1023);
      chk("strobe_spacing", s1 - s0, 1024);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
